// File: rtl/spi_rgb_ctrl.sv
// spi_rgb_ctrl: SPI mode-0 slave driving three shadowed 8-bit PWM channels and a test-mode bit.
// Define SPI_RGB_READBACK_EN to enable command 0x03 readback of the shadow duties on spi_miso.
module spi_rgb_ctrl #(
    parameter int PWM_PRESCALE = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic spi_clk,
    input  logic spi_cs_n,
    input  logic spi_mosi,
    output logic spi_miso,
    output logic pwm_r,
    output logic pwm_g,
    output logic pwm_b,
    output logic test_mode,
    output logic frame_err
);
    logic [2:0] sclk_q, cs_q;
    logic [1:0] mosi_q;
    logic [6:0] shift;
    logic [7:0] rx_byte, cmd, st_r, st_g, st_b, sh_r, sh_g, sh_b, act_r, act_g, act_b, cnt;
    logic [2:0] bit_cnt, byte_cnt;
    logic [15:0] pre;
    logic sclk_rise, cs_rise, cs_fall, active, seen_clk, commit_p, frame_ok, rd_ok, tm, err_q;

    assign sclk_rise = sclk_q[1] & ~sclk_q[2];
    assign cs_rise = cs_q[1] & ~cs_q[2];
    assign cs_fall = ~cs_q[1] & cs_q[2];
    assign rx_byte = {shift, mosi_q[1]};
    assign frame_ok = seen_clk && bit_cnt == 3'd0 &&
                      ((cmd == 8'h01 && byte_cnt == 3'd4) || (cmd == 8'h02 && byte_cnt == 3'd2) || rd_ok);

    // cs_q resets to "low" so a cs_n held low across reset never looks like a new frame start
    always_ff @(posedge clk) begin
        if (rst) begin
            sclk_q <= 3'b000;
            cs_q <= 3'b000;
            mosi_q <= 2'b00;
            shift <= 7'd0;
            bit_cnt <= 3'd0;
            byte_cnt <= 3'd0;
            cmd <= 8'd0;
            st_r <= 8'd0;
            st_g <= 8'd0;
            st_b <= 8'd0;
            sh_r <= 8'd0;
            sh_g <= 8'd0;
            sh_b <= 8'd0;
            active <= 1'b0;
            seen_clk <= 1'b0;
            commit_p <= 1'b0;
            tm <= 1'b0;
            err_q <= 1'b0;
        end else begin
            sclk_q <= {sclk_q[1:0], spi_clk};
            cs_q <= {cs_q[1:0], spi_cs_n};
            mosi_q <= {mosi_q[0], spi_mosi};
            commit_p <= cs_rise;
            err_q <= commit_p & active & seen_clk & ~frame_ok;
            if (commit_p && active) begin
                active <= 1'b0;
                if (frame_ok && cmd == 8'h01) begin
                    sh_r <= st_r;
                    sh_g <= st_g;
                    sh_b <= st_b;
                end
                if (frame_ok && cmd == 8'h02)
                    tm <= st_r[0];
            end
            if (cs_fall) begin
                active <= 1'b1;
                seen_clk <= 1'b0;
                bit_cnt <= 3'd0;
                byte_cnt <= 3'd0;
            end else if (sclk_rise && active && !cs_q[1]) begin
                seen_clk <= 1'b1;
                shift <= rx_byte[6:0];
                bit_cnt <= bit_cnt + 3'd1;
                if (bit_cnt == 3'd7) begin
                    byte_cnt <= byte_cnt == 3'd7 ? 3'd7 : byte_cnt + 3'd1;
                    if (byte_cnt == 3'd0) cmd <= rx_byte;
                    if (byte_cnt == 3'd1) st_r <= rx_byte;
                    if (byte_cnt == 3'd2) st_g <= rx_byte;
                    if (byte_cnt == 3'd3) st_b <= rx_byte;
                end
            end
        end
    end

    // active duties only follow the shadows at the 255->0 wrap
    always_ff @(posedge clk) begin
        if (rst) begin
            pre <= 16'd0;
            cnt <= 8'd0;
            act_r <= 8'd0;
            act_g <= 8'd0;
            act_b <= 8'd0;
        end else if (pre == 16'(PWM_PRESCALE - 1)) begin
            pre <= 16'd0;
            cnt <= cnt + 8'd1;
            if (cnt == 8'd255) begin
                act_r <= sh_r;
                act_g <= sh_g;
                act_b <= sh_b;
            end
        end else begin
            pre <= pre + 16'd1;
        end
    end

`ifdef SPI_RGB_READBACK_EN
    logic sclk_fall, miso_q;
    logic [7:0] rd_byte;
    assign sclk_fall = ~sclk_q[1] & sclk_q[2];
    assign rd_ok = cmd == 8'h03 && byte_cnt == 3'd4;
    assign rd_byte = byte_cnt == 3'd1 ? sh_r : byte_cnt == 3'd2 ? sh_g : sh_b;
    always_ff @(posedge clk) begin
        if (rst || cs_q[1])
            miso_q <= 1'b0;
        else if (sclk_fall)
            miso_q <= active && cmd == 8'h03 && byte_cnt >= 3'd1 && byte_cnt <= 3'd3 ? rd_byte[~bit_cnt] : 1'b0;
    end
    assign spi_miso = miso_q;
`else
    assign rd_ok = 1'b0;
    assign spi_miso = 1'b0;
`endif

    assign pwm_r = cnt < act_r;
    assign pwm_g = cnt < act_g;
    assign pwm_b = cnt < act_b;
    assign test_mode = tm;
    assign frame_err = err_q;
endmodule

// File: tb/tb_spi_rgb_ctrl.sv
// tb_spi_rgb_ctrl: randomized self-checking bench for spi_rgb_ctrl against a frame-level reference model.
module tb_spi_rgb_ctrl;
    logic clk = 1'b0, rst = 1'b1, spi_clk = 1'b0, spi_cs_n = 1'b1, spi_mosi = 1'b0;
    logic spi_miso, pwm_r, pwm_g, pwm_b, test_mode, frame_err;
    int tests = 0, fails = 0, cyc = 0, err_pulses = 0;
    logic [7:0] exp_sh [3];
    logic [7:0] exp_act [3];
    logic [7:0] rxb [4];
    logic exp_tm;
    int hi [3];
    int bad [3];

    spi_rgb_ctrl #(.PWM_PRESCALE(1)) dut (
        .clk(clk), .rst(rst), .spi_clk(spi_clk), .spi_cs_n(spi_cs_n), .spi_mosi(spi_mosi),
        .spi_miso(spi_miso), .pwm_r(pwm_r), .pwm_g(pwm_g), .pwm_b(pwm_b),
        .test_mode(test_mode), .frame_err(frame_err)
    );

    always #5 clk = ~clk;
    // with a prescale of 1 the PWM counter equals cycles since reset modulo 256
    always @(posedge clk) cyc <= rst ? 0 : cyc + 1;
    always @(negedge clk) if (frame_err === 1'b1) err_pulses <= err_pulses + 1;

    task automatic clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic cs_low;
        @(negedge clk) spi_cs_n = 1'b0;
        clks(8);
    endtask

    task automatic cs_high;
        clks(8);
        spi_cs_n = 1'b1;
    endtask

    task automatic send_bits(input logic [7:0] b, input int n, output logic [7:0] rx);
        rx = 8'h00;
        for (int i = 7; i > 7 - n; i--) begin
            spi_mosi = b[i];
            clks(8);
            rx[i] = spi_miso;
            spi_clk = 1'b1;
            clks(8);
            spi_clk = 1'b0;
        end
    endtask

    task automatic frame(input logic [31:0] data, input int nbytes, input int xbits);
        logic [7:0] r;
        cs_low();
        for (int k = 0; k < nbytes; k++) begin
            send_bits(data[31 - 8 * k -: 8], 8, r);
            rxb[k] = r;
        end
        if (xbits > 0) send_bits(8'hA5, xbits, r);
        cs_high();
    endtask

    task automatic wait_wrap;
        for (int i = 0; i < 600; i++) begin
            clks(1);
            if (cyc % 256 == 0) break;
        end
        tests++;
        if (cyc % 256 != 0) begin
            fails++;
            $display("FAIL wrap_wait: counter phase %0d, required 0", cyc % 256);
        end
        exp_act = exp_sh;
    endtask

    task automatic measure;
        logic [2:0] p;
        int c;
        for (int ch = 0; ch < 3; ch++) begin
            hi[ch] = 0;
            bad[ch] = 0;
        end
        for (int i = 0; i < 256; i++) begin
            c = cyc % 256;
            p = {pwm_r, pwm_g, pwm_b};
            for (int ch = 0; ch < 3; ch++) begin
                if (p[2 - ch] === 1'b1) hi[ch]++;
                if (p[2 - ch] !== (c < int'(exp_act[ch]))) bad[ch]++;
            end
            clks(1);
        end
    endtask

    task automatic test_reset;
        clks(4);
        tests++;
        if ({pwm_r, pwm_g, pwm_b, test_mode, frame_err, spi_miso} !== 6'b0) begin
            fails++;
            $display("FAIL reset_outputs: got %b, required 000000", {pwm_r, pwm_g, pwm_b, test_mode, frame_err, spi_miso});
        end
        rst = 1'b0;
        exp_sh = '{8'h00, 8'h00, 8'h00};
        exp_act = exp_sh;
        exp_tm = 1'b0;
    endtask

    task automatic test_set_rgb;
        int e0 = err_pulses;
        frame(32'h0180_00FF, 4, 0);
        clks(6);
        exp_sh = '{8'h80, 8'h00, 8'hFF};
        tests++;
        if (err_pulses != e0) begin
            fails++;
            $display("FAIL rgb_err: pulses %0d, required 0", err_pulses - e0);
        end
        wait_wrap();
        measure();
        for (int ch = 0; ch < 3; ch++) begin
            tests++;
            if (hi[ch] != int'(exp_sh[ch]) || bad[ch] != 0) begin
                fails++;
                $display("FAIL rgb_duty ch%0d: high %0d bad %0d, required high %0d bad 0", ch, hi[ch], bad[ch], exp_sh[ch]);
            end
        end
    endtask

    task automatic test_short_frame;
        logic [7:0] r;
        int e0 = err_pulses;
        cs_low();
        send_bits(8'h01, 8, r);
        send_bits(8'h10, 8, r);
        send_bits(8'h20, 8, r);
        cs_high();
        repeat (3) @(posedge clk);
        @(negedge clk);
        tests++;
        if (frame_err !== 1'b0) begin
            fails++;
            $display("FAIL short_early: frame_err %b, required 0", frame_err);
        end
        @(negedge clk);
        tests++;
        if (frame_err !== 1'b1) begin
            fails++;
            $display("FAIL short_pulse: frame_err %b, required 1", frame_err);
        end
        @(negedge clk);
        tests++;
        if (frame_err !== 1'b0) begin
            fails++;
            $display("FAIL short_width: frame_err %b, required 0", frame_err);
        end
        clks(4);
        tests++;
        if (err_pulses - e0 != 1) begin
            fails++;
            $display("FAIL short_count: pulses %0d, required 1", err_pulses - e0);
        end
        wait_wrap();
        measure();
        tests++;
        if (hi[0] != int'(exp_sh[0]) || hi[1] != int'(exp_sh[1]) || hi[2] != int'(exp_sh[2])) begin
            fails++;
            $display("FAIL short_duty: high %0d/%0d/%0d, required %0d/%0d/%0d", hi[0], hi[1], hi[2], exp_sh[0], exp_sh[1], exp_sh[2]);
        end
    endtask

    task automatic test_mode_set;
        logic [7:0] r;
        int e0 = err_pulses;
        cs_low();
        send_bits(8'h02, 8, r);
        send_bits(8'h01, 8, r);
        cs_high();
        repeat (3) @(posedge clk);
        @(negedge clk);
        tests++;
        if (test_mode !== 1'b0) begin
            fails++;
            $display("FAIL mode_early: test_mode %b, required 0", test_mode);
        end
        @(negedge clk);
        tests++;
        if (test_mode !== 1'b1) begin
            fails++;
            $display("FAIL mode_set: test_mode %b, required 1", test_mode);
        end
        frame(32'h02FE_0000, 2, 0);
        clks(6);
        exp_tm = 1'b0;
        tests++;
        if (test_mode !== exp_tm || err_pulses != e0) begin
            fails++;
            $display("FAIL mode_clear: test_mode %b pulses %0d, required 0 and 0", test_mode, err_pulses - e0);
        end
    endtask

    task automatic test_shadow;
        logic [7:0] r;
        int c = -1, nb = 0;
        cs_low();
        send_bits(8'h01, 8, r);
        for (int k = 0; k < 3; k++) send_bits(8'h40, 8, r);
        clks(8);
        for (int i = 0; i < 300 && cyc % 256 != 96; i++) clks(1);
        spi_cs_n = 1'b1;
        for (int i = 0; i < 300; i++) begin
            clks(1);
            c = cyc % 256;
            if (c == 0) break;
            if (pwm_r !== (c < int'(exp_act[0])) || pwm_g !== (c < int'(exp_act[1])) || pwm_b !== (c < int'(exp_act[2]))) nb++;
        end
        tests++;
        if (nb != 0 || c != 0) begin
            fails++;
            $display("FAIL shadow_hold: bad %0d phase %0d, required 0 and 0", nb, c);
        end
        exp_sh = '{8'h40, 8'h40, 8'h40};
        exp_act = exp_sh;
        measure();
        tests++;
        if (hi[0] != 64 || hi[1] != 64 || hi[2] != 64 || bad[0] + bad[1] + bad[2] != 0) begin
            fails++;
            $display("FAIL shadow_new: high %0d/%0d/%0d, required 64 each", hi[0], hi[1], hi[2]);
        end
    endtask

    task automatic test_rst_mid_frame;
        logic [7:0] r;
        int e0 = err_pulses;
        cs_low();
        send_bits(8'h01, 8, r);
        send_bits(8'h99, 8, r);
        rst = 1'b1;
        clks(3);
        tests++;
        if ({pwm_r, pwm_g, pwm_b, test_mode, frame_err} !== 5'b0) begin
            fails++;
            $display("FAIL rst_mid_out: got %b, required 00000", {pwm_r, pwm_g, pwm_b, test_mode, frame_err});
        end
        rst = 1'b0;
        exp_sh = '{8'h00, 8'h00, 8'h00};
        exp_act = exp_sh;
        exp_tm = 1'b0;
        send_bits(8'hAB, 8, r);
        send_bits(8'hCD, 8, r);
        cs_high();
        clks(6);
        frame(32'h0111_2233, 4, 0);
        clks(6);
        exp_sh = '{8'h11, 8'h22, 8'h33};
        tests++;
        if (err_pulses != e0) begin
            fails++;
            $display("FAIL rst_mid_err: pulses %0d, required 0", err_pulses - e0);
        end
        wait_wrap();
        measure();
        tests++;
        if (hi[0] != 'h11 || hi[1] != 'h22 || hi[2] != 'h33 || bad[0] + bad[1] + bad[2] != 0) begin
            fails++;
            $display("FAIL rst_mid_duty: high %0d/%0d/%0d, required 17/34/51", hi[0], hi[1], hi[2]);
        end
    endtask

    task automatic test_readback;
        int e0;
        frame(32'h01AA_550F, 4, 0);
        clks(6);
        exp_sh = '{8'hAA, 8'h55, 8'h0F};
        e0 = err_pulses;
        frame(32'h0300_0000, 4, 0);
        clks(6);
`ifdef SPI_RGB_READBACK_EN
        tests++;
        if ({rxb[0], rxb[1], rxb[2], rxb[3]} !== {8'h00, exp_sh[0], exp_sh[1], exp_sh[2]} || err_pulses != e0) begin
            fails++;
            $display("FAIL readback: miso %h %h %h %h pulses %0d, required 00 aa 55 0f and 0", rxb[0], rxb[1], rxb[2], rxb[3], err_pulses - e0);
        end
`else
        tests++;
        if ({rxb[0], rxb[1], rxb[2], rxb[3]} !== 32'h0 || err_pulses - e0 != 1) begin
            fails++;
            $display("FAIL readback_off: miso %h %h %h %h pulses %0d, required zeros and 1", rxb[0], rxb[1], rxb[2], rxb[3], err_pulses - e0);
        end
`endif
    endtask

    task automatic test_random;
        logic [31:0] d;
        int kind, nbytes, xbits, e0;
        bit want_err;
        for (int it = 0; it < 10; it++) begin
            kind = $urandom_range(0, 5);
            d = $urandom;
            nbytes = 4;
            xbits = 0;
            want_err = 1'b1;
            e0 = err_pulses;
            case (kind)
                0: begin d[31:24] = 8'h01; want_err = 1'b0; end
                1: begin d[31:24] = 8'h02; nbytes = 2; want_err = 1'b0; end
                2: begin d[31:24] = 8'h01; nbytes = $urandom_range(1, 3); end
                3: begin d[31:24] = 8'h01; xbits = $urandom_range(1, 7); end
                4: d[31:24] = 8'($urandom_range(4, 255));
                default: begin nbytes = 0; want_err = 1'b0; end
            endcase
            frame(d, nbytes, xbits);
            clks(6);
            if (kind == 0) exp_sh = '{d[23:16], d[15:8], d[7:0]};
            if (kind == 1) exp_tm = d[16];
            tests++;
            if (err_pulses - e0 != int'(want_err) || test_mode !== exp_tm) begin
                fails++;
                $display("FAIL rand%0d kind%0d: pulses %0d test_mode %b, required %0d and %b", it, kind, err_pulses - e0, test_mode, want_err, exp_tm);
            end
            wait_wrap();
            measure();
            tests++;
            if (hi[0] != int'(exp_sh[0]) || hi[1] != int'(exp_sh[1]) || hi[2] != int'(exp_sh[2]) || bad[0] + bad[1] + bad[2] != 0) begin
                fails++;
                $display("FAIL rand%0d_duty: high %0d/%0d/%0d, required %0d/%0d/%0d", it, hi[0], hi[1], hi[2], exp_sh[0], exp_sh[1], exp_sh[2]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_set_rgb();
        test_short_frame();
        test_mode_set();
        test_shadow();
        test_rst_mid_frame();
        test_readback();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/spi_rgb_ctrl.md
SPI_RGB_CTRL -- requirements
Module: spi_rgb_ctrl

Interface
REQ-001 SHALL have parameter PWM_PRESCALE, default 4, giving the number of clk cycles per PWM counter step (legal range 1..65535).
REQ-002 SHALL have port clk, input, 1: system clock (PLL output); all logic is in this one clock domain.
REQ-003 SHALL have port rst, input, 1: reset, synchronous and active-high.
REQ-004 SHALL have port spi_clk, input, 1: SPI clock from ESP32, asynchronous to clk.
REQ-005 SHALL have port spi_cs_n, input, 1: SPI chip select, active-low, asynchronous.
REQ-006 SHALL have port spi_mosi, input, 1: SPI data in, asynchronous.
REQ-007 SHALL have port spi_miso, output, 1: SPI data out.
REQ-008 SHALL have ports pwm_r, pwm_g, pwm_b, output, 1 each: PWM drive feeding the RGB LED wrapper in_r/in_g/in_b.
REQ-009 SHALL have port test_mode, output, 1: test-mode select for the RGB LED wrapper.
REQ-010 SHALL have port frame_err, output, 1: one-clk pulse on a rejected frame.

Function
REQ-011 SHALL pass spi_clk, spi_cs_n and spi_mosi through 2-flop synchronizers and detect spi_clk edges on the synchronized signal; correct operation requires clk >= 4x spi_clk.
REQ-012 SHALL implement SPI mode 0: sample MOSI on a detected spi_clk rising edge, MSB first, 8-bit bytes, with a byte counter (saturating at 7) cleared on cs_n falling.
REQ-013 SHALL treat byte 0 as the command: 0x01 SET_RGB (bytes 1..3 = R,G,B), 0x02 SET_MODE (byte 1 bit0 = test_mode, other bits ignored), 0x03 READ (see Configuration).
REQ-014 SHALL stage payload bytes and commit them only on a detected cs_n rising edge, when exactly the command's length (SET_RGB 4, SET_MODE 2) has been received with no partial byte.
REQ-015 SHALL commit on the clk cycle after the synchronized cs_n rising edge is detected: 3 clk cycles after the first clk edge that samples spi_cs_n high.
REQ-016 SHALL, on a wrong byte count, a partial byte, or an unknown command, discard the frame, leave all registers unchanged, and pulse frame_err for exactly 1 clk at commit time.
REQ-017 SHALL ignore a cs_n low period with zero spi_clk edges, with no frame_err.
REQ-018 SHALL hold committed duties in active registers and load new values into shadow registers.
REQ-019 SHALL copy the shadow registers into the active registers only when the PWM counter wraps 255->0, so no glitched period occurs.
REQ-020 SHALL provide the PWM as an 8-bit counter, advancing once per PWM_PRESCALE clk cycles and wrapping 255->0.
REQ-021 SHALL drive pwm_x = (counter < active_duty_x), so duty 0 is constant low and duty 255 is high for 255 of 256 steps.
REQ-022 SHALL update test_mode on commit, without waiting for a PWM boundary.
REQ-023 SHALL, when cs_n rises mid-byte, abort and reject the frame per REQ-016.

Reset
REQ-024 SHALL, while rst=1, clear the shift register, byte counter, staged/shadow/active duties, PWM counter and prescaler.
REQ-025 SHALL hold outputs while rst=1 at pwm_r=pwm_g=pwm_b=0, test_mode=0, frame_err=0, spi_miso=0.
REQ-026 SHALL discard any in-flight frame on reset and require a new cs_n falling edge before accepting bytes after reset.

Configuration
REQ-027 SHALL implement readback when SPI_RGB_READBACK_EN is defined: for command 0x03, spi_miso shifts out the shadow R,G,B in bytes 1..3, MSB first, each bit updated 1 clk after a detected spi_clk falling edge, and 0 at all other times.
REQ-028 SHALL, when SPI_RGB_READBACK_EN is undefined, tie spi_miso to 0 and treat 0x03 as an unknown command (frame_err).

Verification
REQ-029 SHALL cover: SET_RGB frame 01 80 00 FF, PWM_PRESCALE=1 -> after the next counter wrap, pwm_r is high for 128 of 256 clks, pwm_g constant 0, pwm_b high for 255 of 256.
REQ-030 SHALL cover: frame 01 10 20 (3 bytes) -> frame_err pulses once, 3 clks after cs_n rises; duties unchanged.
REQ-031 SHALL cover: frame 02 01 -> test_mode=1 exactly 3 clks after cs_n rises; then 02 FE -> test_mode=0.
REQ-032 SHALL cover: SET_RGB 01 40 40 40 committed at counter=100 -> outputs still follow the old duty until the counter wraps to 0, then use 0x40.
REQ-033 SHALL cover: rst asserted mid-frame after 2 bytes, released, then a complete 01 11 22 33 -> only 11/22/33 applied, no frame_err.
REQ-034 SHALL cover, with SPI_RGB_READBACK_EN: after 01 AA 55 0F, frame 03 00 00 00 -> MISO bytes 1..3 read AA 55 0F; without the macro, MISO reads 0 and frame_err pulses.
